// File: rtl/register_file_mp_pkg.sv
// Shared defaults and address-validity helper for the multi-port register file.
package register_file_mp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    // An address is writable/readable only if implemented and not the hardwired zero register.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned num_regs,
                                        input logic        zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/register_file_mp_read_port.sv
// One read port: decode, same-cycle bypass, zero/invalid masking and optional output register.
module register_file_mp_read_port
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 8,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem [NUM_REGS],
    input  logic              wen0_ok,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              wen1_ok,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] data
);

    logic              rd_ok;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rd_q;

    assign rd_ok = addr_valid(32'(addr), NUM_REGS, ZERO_REG != 0);

    always_comb begin
        rd_val = '0;
        if (rd_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) rd_val = mem[i];
            end
            // Port 1 wins a collision, so it also wins the forward.
            if (BYPASS != 0) begin
                if (wen1_ok && (wa1 == addr))      rd_val = wd1;
                else if (wen0_ok && (wa0 == addr)) rd_val = wd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_val;
    end

    assign data = (READ_LAT != 0) ? rd_q : rd_val;

endmodule

// File: rtl/register_file_mp.sv
// Two-write / two-read register file with collision flag, bypass and selectable read latency.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 8,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WEN0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [DATA_W-1:0] busW0,
    input  logic              WEN1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] busW1,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    output logic              WCOLL
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wen0_ok;
    logic              wen1_ok;
    logic              wcoll_q;

    assign wen0_ok = WEN0 && addr_valid(32'(RW0), NUM_REGS, ZERO_REG != 0);
    assign wen1_ok = WEN1 && addr_valid(32'(RW1), NUM_REGS, ZERO_REG != 0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            wcoll_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wen1_ok && (RW1 == ADDR_W'(i)))      mem[i] <= busW1;
                else if (wen0_ok && (RW0 == ADDR_W'(i))) mem[i] <= busW0;
            end
            wcoll_q <= wen0_ok && wen1_ok && (RW0 == RW1);
        end
    end

    assign WCOLL = wcoll_q;

    register_file_mp_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .READ_LAT(READ_LAT), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd_x (
        .clk(Clk), .rst(Rst), .addr(RX), .mem(mem),
        .wen0_ok(wen0_ok), .wa0(RW0), .wd0(busW0),
        .wen1_ok(wen1_ok), .wa1(RW1), .wd1(busW1),
        .data(busX)
    );

    register_file_mp_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .READ_LAT(READ_LAT), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd_y (
        .clk(Clk), .rst(Rst), .addr(RY), .mem(mem),
        .wen0_ok(wen0_ok), .wa0(RW0), .wd0(busW0),
        .wen1_ok(wen1_ok), .wa1(RW1), .wd1(busW1),
        .data(busY)
    );

endmodule
